// File: rtl/button_step_gen.sv
`default_nettype none
// ============================================================================
//  Module   : button_step_gen
//  Purpose  : Turns the debounced level of a push-button into single-cycle
//             step strobes for the CPU single-step / manual-clock-enable
//             logic. A press gives one strobe immediately. While the button
//             stays down, auto-repeat starts HOLD_DELAY cycles after the
//             press strobe and then fires every REPEAT_PERIOD cycles.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    HOLD_DELAY     cycles from the press strobe to the first repeat (>= 2)
//    REPEAT_PERIOD  cycles between repeat strobes                   (>= 2)
//  Ports
//    clk            in   system clock, rising edge
//    rst            in   synchronous reset, active-high
//    clean_button   in   debounced button level, synchronous to clk
//    enable         in   low forces IDLE and suppresses all strobes
//    step_pulse     out  registered one-cycle step strobe
//    held           out  registered, high in HOLD or REPEAT
//    repeat_active  out  registered, high in REPEAT
//    step_count     out  [15:0] strobe counter (only with STEP_COUNT_EN)
//  Build option
//    STEP_COUNT_EN  adds the wrapping 16-bit step_count output
// ============================================================================
module button_step_gen #(
  parameter int HOLD_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clean_button,
  input  logic        enable,
  output logic        step_pulse,
`ifdef STEP_COUNT_EN
  output logic [15:0] step_count,
`endif
  output logic        held,
  output logic        repeat_active
);

  // The counter only ever has to reach (limit-1) of the larger limit.
  localparam int c_MAX_LIMIT = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY
                                                              : REPEAT_PERIOD;
  localparam int c_CNT_W     = $clog2(c_MAX_LIMIT);

  localparam logic [c_CNT_W-1:0] c_HOLD_LAST   = c_CNT_W'(HOLD_DELAY - 1);
  localparam logic [c_CNT_W-1:0] c_REPEAT_LAST = c_CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_btn_q;
  logic                 r_step_pulse;
  logic                 r_held;
  logic                 r_repeat_active;
`ifdef STEP_COUNT_EN
  logic [15:0]          r_step_count;
`endif

  // Rising edge of the debounced level. After reset r_btn_q is 0, so a
  // button still held through reset is seen as a fresh press.
  logic w_press;
  assign w_press = clean_button & ~r_btn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_count         <= '0;
      r_btn_q         <= 1'b0;
      r_step_pulse    <= 1'b0;
      r_held          <= 1'b0;
      r_repeat_active <= 1'b0;
`ifdef STEP_COUNT_EN
      r_step_count    <= 16'd0;
`endif
    end else begin
      // Edge history tracks the button regardless of enable or state, so
      // re-enabling with the button already down never looks like a press.
      r_btn_q      <= clean_button;
      r_step_pulse <= 1'b0;

      if (!enable) begin
        r_state         <= ST_IDLE;
        r_count         <= '0;
        r_held          <= 1'b0;
        r_repeat_active <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_press) begin
              r_step_pulse    <= 1'b1;
              r_state         <= ST_HOLD;
              r_count         <= '0;
              r_held          <= 1'b1;
              r_repeat_active <= 1'b0;
`ifdef STEP_COUNT_EN
              r_step_count    <= r_step_count + 16'd1;
`endif
            end
          end

          ST_HOLD: begin
            // Release is checked first so it wins over a coinciding expiry.
            if (!clean_button) begin
              r_state         <= ST_IDLE;
              r_count         <= '0;
              r_held          <= 1'b0;
              r_repeat_active <= 1'b0;
            end else if (r_count == c_HOLD_LAST) begin
              r_step_pulse    <= 1'b1;
              r_state         <= ST_REPEAT;
              r_count         <= '0;
              r_held          <= 1'b1;
              r_repeat_active <= 1'b1;
`ifdef STEP_COUNT_EN
              r_step_count    <= r_step_count + 16'd1;
`endif
            end else begin
              r_count <= r_count + 1'b1;
            end
          end

          ST_REPEAT: begin
            if (!clean_button) begin
              r_state         <= ST_IDLE;
              r_count         <= '0;
              r_held          <= 1'b0;
              r_repeat_active <= 1'b0;
            end else if (r_count == c_REPEAT_LAST) begin
              r_step_pulse    <= 1'b1;
              r_count         <= '0;
`ifdef STEP_COUNT_EN
              r_step_count    <= r_step_count + 16'd1;
`endif
            end else begin
              r_count <= r_count + 1'b1;
            end
          end

          default: begin
            // Unused encoding: recover quietly to IDLE.
            r_state         <= ST_IDLE;
            r_count         <= '0;
            r_held          <= 1'b0;
            r_repeat_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign step_pulse    = r_step_pulse;
  assign held          = r_held;
  assign repeat_active = r_repeat_active;
`ifdef STEP_COUNT_EN
  assign step_count    = r_step_count;
`endif

endmodule
`default_nettype wire

// File: doc/button_step_gen.md
Name: button_step_gen

Overview:
- Sits directly downstream of the button debouncer.
- Converts the debounced level of a push-button into single-cycle step pulses for the multicycle CPU's single-step / manual-clock-enable logic.
- One pulse per press. If the button is held, auto-repeat starts after an initial hold delay and then repeats at a fixed period.
- Provides status outputs for board LEDs.

Parameters:
- HOLD_DELAY, 50_000_000, cycles between the press pulse and the first auto-repeat pulse (0.5 s at 100 MHz); must be >= 2.
- REPEAT_PERIOD, 10_000_000, cycles between consecutive auto-repeat pulses (100 ms at 100 MHz); must be >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- clean_button  input  1  debounced button level from the debouncer; already synchronous to clk.
- enable  input  1  step generation enable; low suppresses all pulses.
- step_pulse  output  1  registered one-cycle step strobe.
- held  output  1  registered; high while FSM is in HOLD or REPEAT.
- repeat_active  output  1  registered; high while FSM is in REPEAT.

Behaviour:
- Interface:
  - Single clock domain.
  - Reset is synchronous and active-high: sampled only on the rising edge of clk.
- Reset values: step_pulse=0, held=0, repeat_active=0, state=IDLE, counter=0, btn_q=0.
- btn_q:
  - Registers clean_button every cycle, regardless of enable or state.
  - Press edge = clean_button & ~btn_q.
- Counter:
  - Sized to $clog2(max(HOLD_DELAY, REPEAT_PERIOD)) bits.
  - Never exceeds (limit-1) of the current state.
  - Cleared on every state change.
- step_pulse:
  - Defaults to 0 every cycle.
  - Never high for two consecutive cycles: both limits are >= 2.
- FSM states: IDLE, HOLD, REPEAT.
- IDLE:
  - On press edge with enable=1: step_pulse<=1, state<=HOLD, counter<=0.
  - The pulse is visible the cycle after the edge that first samples clean_button high (1-cycle latency).
- HOLD:
  - If clean_button=0: state<=IDLE, no pulse.
  - Else if counter==HOLD_DELAY-1: step_pulse<=1, state<=REPEAT, counter<=0.
  - Else counter+1.
  - Result: the first repeat pulse comes exactly HOLD_DELAY cycles after the press pulse.
- REPEAT:
  - If clean_button=0: state<=IDLE, no pulse.
  - Else if counter==REPEAT_PERIOD-1: step_pulse<=1, counter<=0.
  - Else counter+1.
- Release coinciding with counter expiry: the release wins. No pulse is issued and the FSM goes to IDLE.
- Release never produces a pulse.
- enable=0, in any state:
  - state<=IDLE, counter<=0, step_pulse<=0.
  - btn_q keeps tracking clean_button.
- enable rising while the button is already held: no pulse. A new press edge (release then press) is required.
- Press edge and enable rising in the same cycle: the pulse is issued (enable is sampled that cycle).
- Reset mid-HOLD or mid-REPEAT:
  - All registers take their reset values on that edge, including btn_q=0.
  - If the button is still high after reset deasserts, this counts as a press edge and a pulse follows.
- held = (state!=IDLE); repeat_active = (state==REPEAT). Both are registered alongside state.

Optional Feature:
- Macro: STEP_COUNT_EN.
- Defined:
  - Adds output step_count [15:0], reset 0.
  - Increments by 1 in the same edge that sets step_pulse.
  - Wraps from 16'hFFFF to 0.
  - Unaffected by enable except that no pulse means no increment.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan (HOLD_DELAY=8, REPEAT_PERIOD=4 on the bench):
- Reset with clean_button=0 -> all outputs 0 for 5 cycles after rst deasserts.
- Single tap: clean_button high for 3 cycles, enable=1 -> exactly one step_pulse, 1 cycle after the first high sample; held high for 3 cycles then 0.
- Hold for 30 cycles -> pulses at relative cycles 0, 8, 12, 16, 20, 24, 28 (7 pulses); repeat_active asserts with the cycle-8 pulse; after release held=0 next cycle and no further pulses.
- Release on the exact cycle the counter reaches 7 in HOLD -> no pulse, state IDLE, held=0.
- enable=0 during a press then enable=1 while still held -> zero pulses; release then re-press -> one pulse.
- rst asserted at cycle 10 of a hold, deasserted with the button still high -> one pulse 1 cycle later, then the repeat schedule restarts from 0. With STEP_COUNT_EN, preload via 65536 pulses -> step_count wraps to 0.
